// File: rtl/result_window_filter.sv
// Sliding-window sum and truncated average over the last DEPTH accepted samples,
// with valid/ready on both sides and one registered output slot.
module result_window_filter #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 4,
    parameter int SUM_W  = DATA_W + $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SUM_W-1:0]         out_sum,
    output logic [DATA_W-1:0]        out_avg,
    output logic [$clog2(DEPTH):0]   fill_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {
        WARMUP,
        STEADY
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]       fillCount_q, fillCount_d;
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic                   outValid_q, outValid_d;
    logic [SUM_W-1:0]       outSum_q, outSum_d;
    logic [DATA_W-1:0]      outAvg_q, outAvg_d;
    logic [DATA_W-1:0]      window_q [DEPTH];

    logic                   accept;
    logic [DATA_W-1:0]      oldest;
    logic [SUM_W-1:0]       sumNext;

    assign in_ready   = (!outValid_q || out_ready) && !clear;
    assign accept     = in_valid && in_ready;
    assign oldest     = (fillCount_q == FULL) ? window_q[wrPtr_q] : '0;
    // Modular SUM_W arithmetic is exact: the true result always fits in SUM_W bits.
    assign sumNext    = sum_q + SUM_W'(in_data) - SUM_W'(oldest);

    assign out_valid  = outValid_q;
    assign out_sum    = outSum_q;
    assign out_avg    = outAvg_q;
    assign fill_count = fillCount_q;

    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        fillCount_d = fillCount_q;
        sum_d       = sum_q;
        outValid_d  = outValid_q;
        outSum_d    = outSum_q;
        outAvg_d    = outAvg_q;

        if (clear) begin
            state_d     = WARMUP;
            wrPtr_d     = '0;
            fillCount_d = '0;
            sum_d       = '0;
        end else if (accept) begin
            wrPtr_d     = wrPtr_q + PTR_W'(1);
            fillCount_d = (fillCount_q == FULL) ? FULL : fillCount_q + CNT_W'(1);
            sum_d       = sumNext;
            state_d     = (fillCount_d == FULL) ? STEADY : WARMUP;
        end

        // A pending output only leaves on consume or is replaced by a fresh steady-state result.
        if (accept && state_d == STEADY) begin
            outValid_d = 1'b1;
            outSum_d   = sumNext;
            outAvg_d   = DATA_W'(sumNext >> PTR_W);
        end else if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WARMUP;
            wrPtr_q     <= '0;
            fillCount_q <= '0;
            sum_q       <= '0;
            outValid_q  <= 1'b0;
            outSum_q    <= '0;
            outAvg_q    <= '0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            fillCount_q <= fillCount_d;
            sum_q       <= sum_d;
            outValid_q  <= outValid_d;
            outSum_q    <= outSum_d;
            outAvg_q    <= outAvg_d;
        end
    end

    // Sample storage is never reset; fillCount_q decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            window_q[wrPtr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_result_window_filter.sv
// Self-checking bench for result_window_filter: table-driven window vectors,
// scoreboard of expected outputs, and hand-written backpressure/clear/reset sequences.
module tb_result_window_filter;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_sum;
    logic [4:0] out_avg;
    logic [2:0] fill_count;

    int testsRun    = 0;
    int testsFailed = 0;
    int expFill     = 0;

    typedef struct {
        logic [4:0] data;
        logic       expValid;
        logic [6:0] expSum;
        logic [4:0] expAvg;
    } vec_t;

    typedef struct {
        logic [6:0] sum;
        logic [4:0] avg;
    } res_t;

    res_t expQ[$];
    vec_t vecs[21];

    result_window_filter #(
        .DATA_W(5),
        .DEPTH (4),
        .SUM_W (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_avg   (out_avg),
        .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Offer one sample, queue its expected result if it should produce one, and check handshake state.
    task automatic applyStimulus(input logic [4:0] data, input logic expValid,
                                 input logic [6:0] expSum, input logic [4:0] expAvg);
        in_valid = 1'b1;
        in_data  = data;
        #1;
        checkOutput("in_ready_before_accept", in_ready, 1);
        if (expValid) expQ.push_back('{expSum, expAvg});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expFill  = (expFill == 4) ? 4 : expFill + 1;
        checkOutput("out_valid_after_accept", out_valid, expValid);
        checkOutput("fill_count", fill_count, expFill);
    endtask

    // Scoreboard: a result is consumed on any edge where out_valid && out_ready.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_output: got sum %0d, expected no output", out_sum);
            end else begin
                res_t e;
                e = expQ.pop_front();
                checkOutput("sb_out_sum", out_sum, e.sum);
                checkOutput("sb_out_avg", out_avg, e.avg);
            end
        end
    end

    initial begin
        // Warm-up, slide/wrap, then saturation at max value and drain with zeros.
        vecs[0]  = '{5'd1,  1'b0, 7'd0,   5'd0};
        vecs[1]  = '{5'd2,  1'b0, 7'd0,   5'd0};
        vecs[2]  = '{5'd3,  1'b0, 7'd0,   5'd0};
        vecs[3]  = '{5'd4,  1'b1, 7'd10,  5'd2};
        vecs[4]  = '{5'd5,  1'b1, 7'd14,  5'd3};
        vecs[5]  = '{5'd6,  1'b1, 7'd18,  5'd4};
        vecs[6]  = '{5'd7,  1'b1, 7'd22,  5'd5};
        vecs[7]  = '{5'd8,  1'b1, 7'd26,  5'd6};
        vecs[8]  = '{5'd9,  1'b1, 7'd30,  5'd7};
        vecs[9]  = '{5'd31, 1'b1, 7'd55,  5'd13};
        vecs[10] = '{5'd31, 1'b1, 7'd79,  5'd19};
        vecs[11] = '{5'd31, 1'b1, 7'd102, 5'd25};
        vecs[12] = '{5'd31, 1'b1, 7'd124, 5'd31};
        vecs[13] = '{5'd31, 1'b1, 7'd124, 5'd31};
        vecs[14] = '{5'd31, 1'b1, 7'd124, 5'd31};
        vecs[15] = '{5'd31, 1'b1, 7'd124, 5'd31};
        vecs[16] = '{5'd31, 1'b1, 7'd124, 5'd31};
        vecs[17] = '{5'd0,  1'b1, 7'd93,  5'd23};
        vecs[18] = '{5'd0,  1'b1, 7'd62,  5'd15};
        vecs[19] = '{5'd0,  1'b1, 7'd31,  5'd7};
        vecs[20] = '{5'd0,  1'b1, 7'd0,   5'd0};

        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_sum", out_sum, 0);
        checkOutput("reset_out_avg", out_avg, 0);
        checkOutput("reset_fill_count", fill_count, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        out_ready = 1'b1;

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].data, vecs[i].expValid, vecs[i].expSum, vecs[i].expAvg);
        end

        // Backpressure: hold the output three cycles while a sample waits at the input.
        applyStimulus(5'd1, 1'b1, 7'd1, 5'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 5'd2;
        repeat (3) begin
            #1;
            checkOutput("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_out_sum_held", out_sum, 1);
            checkOutput("bp_out_avg_held", out_avg, 0);
            checkOutput("bp_fill_count", fill_count, 4);
        end
        out_ready = 1'b1;
        applyStimulus(5'd2, 1'b1, 7'd3,  5'd0);
        applyStimulus(5'd3, 1'b1, 7'd6,  5'd1);
        applyStimulus(5'd4, 1'b1, 7'd10, 5'd2);

        // Clear with a sample offered and an output pending.
        applyStimulus(5'd1, 1'b1, 7'd10, 5'd2);
        applyStimulus(5'd2, 1'b1, 7'd10, 5'd2);
        applyStimulus(5'd3, 1'b1, 7'd10, 5'd2);
        out_ready = 1'b0;
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 5'd9;
        #1;
        checkOutput("clear_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        expFill  = 0;
        checkOutput("clear_fill_count", fill_count, 0);
        checkOutput("clear_pending_valid", out_valid, 1);
        checkOutput("clear_pending_sum", out_sum, 10);
        out_ready = 1'b1;
        applyStimulus(5'd4, 1'b0, 7'd0,  5'd0);
        applyStimulus(5'd4, 1'b0, 7'd0,  5'd0);
        applyStimulus(5'd4, 1'b0, 7'd0,  5'd0);
        applyStimulus(5'd4, 1'b1, 7'd16, 5'd4);

        // Reset mid-steady with a result still pending.
        applyStimulus(5'd5, 1'b1, 7'd17, 5'd4);
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        expFill = 0;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_fill_count", fill_count, 0);
        checkOutput("midreset_out_sum", out_sum, 0);
        checkOutput("midreset_out_avg", out_avg, 0);
        checkOutput("midreset_in_ready", in_ready, 1);
        expQ.delete();
        out_ready = 1'b1;
        applyStimulus(5'd1, 1'b0, 7'd0,  5'd0);
        applyStimulus(5'd2, 1'b0, 7'd0,  5'd0);
        applyStimulus(5'd3, 1'b0, 7'd0,  5'd0);
        applyStimulus(5'd4, 1'b1, 7'd10, 5'd2);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_out_valid", out_valid, 0);
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
